// File: rtl/parity_link_pkg.sv
// Shared types and constants for the serial link that feeds the 8-bit parity checker.
// The frame is start + 8 data bits (LSB first) + parity + stop.
package parity_link_pkg;

    localparam int DATA_W     = 8;
    localparam int FRAME_BITS = 11;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_HIGH
    } rx_state_t;

endpackage

// File: rtl/bit_sync2.sv
// Two-flop synchronizer for one asynchronous level.
// Both flops reset high, so the serial line reads as idle straight out of reset.
module bit_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    // NOTE: sequential state uses non-blocking assignments so every flop samples the pre-edge value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/parity_frame_rx.sv
// Oversampling serial deframer: start + 8 data bits + parity + stop.
// Delivers the byte and the raw parity bit to the downstream parity checker.
module parity_frame_rx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_W       = parity_link_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_in,
    output logic [DATA_W-1:0] data_out,
    output logic              parity_out,
    output logic              data_valid,
    output logic              frame_err,
    output logic              busy
);

    import parity_link_pkg::*;

    localparam int             CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic              rx_s;
    rx_state_t         state;
    rx_state_t         state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [2:0]        bit_idx;
    logic [DATA_W-1:0] shift;
    logic              parity_bit;

    logic cnt_clr;
    logic sample_data;
    logic sample_par;
    logic frame_done;

    bit_sync2 u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (rx_in),
        .q     (rx_s)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt   = state;
        cnt_clr     = 1'b0;
        sample_data = 1'b0;
        sample_par  = 1'b0;
        frame_done  = 1'b0;

        unique case (state)
            IDLE: begin
                cnt_clr = 1'b1;
                if (!rx_s) begin
                    state_nxt = START;
                end
            end

            // A start bit that is high again at mid-bit was a glitch.
            START: begin
                if (cnt == CNT_MID) begin
                    cnt_clr   = 1'b1;
                    state_nxt = rx_s ? IDLE : DATA;
                end
            end

            DATA: begin
                if (cnt == CNT_LAST) begin
                    cnt_clr     = 1'b1;
                    sample_data = 1'b1;
                    if (bit_idx == 3'd7) begin
                        state_nxt = PARITY;
                    end
                end
            end

            PARITY: begin
                if (cnt == CNT_LAST) begin
                    cnt_clr    = 1'b1;
                    sample_par = 1'b1;
                    state_nxt  = STOP;
                end
            end

            STOP: begin
                if (cnt == CNT_LAST) begin
                    cnt_clr    = 1'b1;
                    frame_done = 1'b1;
                    state_nxt  = rx_s ? IDLE : WAIT_HIGH;
                end
            end

            // A line held low after a bad stop bit must not start another frame.
            WAIT_HIGH: begin
                cnt_clr = 1'b1;
                if (rx_s) begin
                    state_nxt = IDLE;
                end
            end

            default: begin
                cnt_clr   = 1'b1;
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (cnt_clr) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_idx <= 3'd0;
        end else if (state != DATA) begin
            bit_idx <= 3'd0;
        end else if (sample_data) begin
            bit_idx <= bit_idx + 3'd1;
        end
    end

    // NOTE: the shift register is reset along with the control state so a
    // partial frame can never leak stale bits into data_out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift      <= '0;
            parity_bit <= 1'b0;
        end else begin
            if (sample_data) begin
                shift[bit_idx] <= rx_s;
            end
            if (sample_par) begin
                parity_bit <= rx_s;
            end
        end
    end

    // Outputs change only when a frame completes and hold until the next one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out   <= '0;
            parity_out <= 1'b0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            data_valid <= frame_done;
            if (frame_done) begin
                data_out   <= shift;
                parity_out <= parity_bit;
                frame_err  <= ~rx_s;
            end
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_parity_frame_rx.sv
// Directed bench for parity_frame_rx: one instance at 16 clocks/bit, one at 4 clocks/bit.
// Monitors record pulse timing and payload; each test task checks inline against hand-computed values.
module tb_parity_frame_rx;

    localparam int CPB_A = 16;
    localparam int CPB_B = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_a = 1'b1;
    logic       rx_b = 1'b1;

    logic [7:0] data_a, data_b;
    logic       par_a, par_b;
    logic       dv_a, dv_b;
    logic       ferr_a, ferr_b;
    logic       busy_a, busy_b;

    int n_pass = 0;
    int n_chk  = 0;
    int cyc    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    parity_frame_rx #(.CLKS_PER_BIT(CPB_A)) dut_a (
        .clk(clk), .rst_n(rst_n), .rx_in(rx_a),
        .data_out(data_a), .parity_out(par_a), .data_valid(dv_a),
        .frame_err(ferr_a), .busy(busy_a)
    );

    parity_frame_rx #(.CLKS_PER_BIT(CPB_B)) dut_b (
        .clk(clk), .rst_n(rst_n), .rx_in(rx_b),
        .data_out(data_b), .parity_out(par_b), .data_valid(dv_b),
        .frame_err(ferr_b), .busy(busy_b)
    );

    // Monitors sample on the falling edge, half a cycle after outputs settle.
    int   start_cyc_a = 0, start_cnt_a = 0, valid_cnt_a = 0, lat_a = 0, gap_a = 0, prev_v_a = 0, wide_a = 0;
    logic busy_q_a = 1'b0, dv_q_a = 1'b0;
    int   start_cyc_b = 0, valid_cnt_b = 0, lat_b = 0;
    logic busy_q_b = 1'b0;

    always @(negedge clk) begin
        if (busy_a && !busy_q_a) begin
            start_cyc_a = cyc;
            start_cnt_a++;
        end
        busy_q_a = busy_a;
        if (dv_a) begin
            if (dv_q_a) wide_a++;
            else begin
                valid_cnt_a++;
                lat_a    = cyc - start_cyc_a;
                gap_a    = cyc - prev_v_a;
                prev_v_a = cyc;
            end
        end
        dv_q_a = dv_a;
    end

    always @(negedge clk) begin
        if (busy_b && !busy_q_b) start_cyc_b = cyc;
        busy_q_b = busy_b;
        if (dv_b) begin
            valid_cnt_b++;
            lat_b = cyc - start_cyc_b;
        end
    end

    task automatic set_line(input int sel, input logic v);
        if (sel == 0) rx_a = v;
        else          rx_b = v;
    endtask

    // Called on a falling edge; returns on the falling edge that ends the stop bit.
    task automatic send_frame(input int sel, input logic [7:0] d, input logic p, input logic s);
        logic [10:0] bits;
        int          cpb;
        bits = {s, p, d, 1'b0};
        cpb  = (sel == 0) ? CPB_A : CPB_B;
        for (int i = 0; i < 11; i++) begin
            set_line(sel, bits[i]);
            repeat (cpb) @(negedge clk);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_chk++; if (data_a !== 8'h00) $display("FAIL reset_data got %h want 00", data_a); else n_pass++;
        n_chk++; if ({par_a, dv_a, ferr_a, busy_a} !== 4'b0000)
            $display("FAIL reset_ctrl got %b want 0000", {par_a, dv_a, ferr_a, busy_a}); else n_pass++;
        n_chk++; if ({data_b, par_b, dv_b, ferr_b, busy_b} !== 12'h000)
            $display("FAIL reset_b got %h want 000", {data_b, par_b, dv_b, ferr_b, busy_b}); else n_pass++;
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_basic;
        int v0;
        v0 = valid_cnt_a;
        send_frame(0, 8'hA5, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        n_chk++; if (valid_cnt_a != v0 + 1) $display("FAIL basic_count got %0d want %0d", valid_cnt_a - v0, 1); else n_pass++;
        n_chk++; if (data_a !== 8'hA5) $display("FAIL basic_data got %h want a5", data_a); else n_pass++;
        n_chk++; if ({par_a, ferr_a} !== 2'b00) $display("FAIL basic_par_ferr got %b want 00", {par_a, ferr_a}); else n_pass++;
        n_chk++; if (lat_a != 168) $display("FAIL basic_latency got %0d want 168", lat_a); else n_pass++;
        n_chk++; if (busy_a !== 1'b0) $display("FAIL basic_busy got %b want 0", busy_a); else n_pass++;
    endtask

    task automatic test_back_to_back;
        send_frame(0, 8'h3C, 1'b1, 1'b1);
        n_chk++; if ({data_a, par_a} !== {8'h3C, 1'b1}) $display("FAIL b2b_first got %h/%b want 3c/1", data_a, par_a); else n_pass++;
        send_frame(0, 8'hFF, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        n_chk++; if ({data_a, par_a} !== {8'hFF, 1'b0}) $display("FAIL b2b_second got %h/%b want ff/0", data_a, par_a); else n_pass++;
        n_chk++; if (gap_a != 176) $display("FAIL b2b_gap got %0d want 176", gap_a); else n_pass++;
        n_chk++; if (wide_a != 0) $display("FAIL b2b_pulse_width got %0d extra cycles want 0", wide_a); else n_pass++;
    endtask

    task automatic test_glitch;
        int v0, s0;
        v0 = valid_cnt_a;
        s0 = start_cnt_a;
        rx_a = 1'b0;
        repeat (4) @(negedge clk);
        rx_a = 1'b1;
        repeat (30) @(negedge clk);
        n_chk++; if (start_cnt_a != s0 + 1) $display("FAIL glitch_start got %0d want 1", start_cnt_a - s0); else n_pass++;
        n_chk++; if (valid_cnt_a != v0) $display("FAIL glitch_valid got %0d want 0", valid_cnt_a - v0); else n_pass++;
        n_chk++; if (busy_a !== 1'b0) $display("FAIL glitch_busy got %b want 0", busy_a); else n_pass++;
        n_chk++; if (data_a !== 8'hFF) $display("FAIL glitch_data got %h want ff", data_a); else n_pass++;
    endtask

    task automatic test_break;
        int v0;
        v0 = valid_cnt_a;
        send_frame(0, 8'h55, 1'b0, 1'b0);
        repeat (40 * CPB_A) @(negedge clk);
        n_chk++; if (valid_cnt_a != v0 + 1) $display("FAIL break_count got %0d want 1", valid_cnt_a - v0); else n_pass++;
        n_chk++; if ({data_a, ferr_a} !== {8'h55, 1'b1}) $display("FAIL break_data_ferr got %h/%b want 55/1", data_a, ferr_a); else n_pass++;
        n_chk++; if (busy_a !== 1'b1) $display("FAIL break_hold got %b want 1", busy_a); else n_pass++;
        rx_a = 1'b1;
        repeat (8) @(negedge clk);
        n_chk++; if (busy_a !== 1'b0) $display("FAIL break_release got %b want 0", busy_a); else n_pass++;
        send_frame(0, 8'h81, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        n_chk++; if ({data_a, ferr_a} !== {8'h81, 1'b0}) $display("FAIL break_recover got %h/%b want 81/0", data_a, ferr_a); else n_pass++;
    endtask

    task automatic test_reset_mid;
        int          v0;
        logic [7:0]  d;
        d  = 8'hE6;
        rx_a = 1'b0;
        repeat (CPB_A) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx_a = d[i];
            repeat (CPB_A) @(negedge clk);
        end
        rx_a = d[4];
        repeat (CPB_A / 2) @(negedge clk);
        v0 = valid_cnt_a;
        n_chk++; if (busy_a !== 1'b1) $display("FAIL rstmid_inframe got %b want 1", busy_a); else n_pass++;
        rst_n = 1'b0;
        #1;
        n_chk++; if ({data_a, par_a, dv_a, busy_a} !== 11'h000)
            $display("FAIL rstmid_outputs got %h want 000", {data_a, par_a, dv_a, busy_a}); else n_pass++;
        rx_a = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (200) @(negedge clk);
        n_chk++; if (valid_cnt_a != v0) $display("FAIL rstmid_no_valid got %0d want 0", valid_cnt_a - v0); else n_pass++;
        send_frame(0, 8'h01, 1'b1, 1'b1);
        repeat (4) @(negedge clk);
        n_chk++; if ({data_a, par_a} !== {8'h01, 1'b1}) $display("FAIL rstmid_after got %h/%b want 01/1", data_a, par_a); else n_pass++;
        n_chk++; if (valid_cnt_a != v0 + 1) $display("FAIL rstmid_count got %0d want 1", valid_cnt_a - v0); else n_pass++;
    endtask

    task automatic test_short_bit;
        int v0;
        v0 = valid_cnt_b;
        send_frame(1, 8'hA5, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        n_chk++; if (valid_cnt_b != v0 + 1) $display("FAIL short_count got %0d want 1", valid_cnt_b - v0); else n_pass++;
        n_chk++; if ({data_b, par_b, ferr_b} !== {8'hA5, 2'b00}) $display("FAIL short_data got %h/%b/%b want a5/0/0", data_b, par_b, ferr_b); else n_pass++;
        n_chk++; if (lat_b != 42) $display("FAIL short_latency got %0d want 42", lat_b); else n_pass++;
        n_chk++; if (busy_b !== 1'b0) $display("FAIL short_busy got %b want 0", busy_b); else n_pass++;
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_basic();
        test_back_to_back();
        test_glitch();
        test_break();
        test_reset_mid();
        test_short_bit();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
